// File: rtl/io_cfg_sequencer.sv
// io_cfg_sequencer: per-I/O configuration table plus a shift/latch sequencer that
// loads the whole table into the I/O buffer ring config chain, last entry first.
module io_cfg_sequencer #(
  parameter int NUM_IO = 3,
  parameter int AW     = 2,
  parameter int CFG_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CFG_W-1:0] wr_data,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wr_err,
  output logic             cfg_sdo,
  output logic             cfg_shift,
  output logic             cfg_latch
);

  localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [AW:0]    NUM_IO_W  = (AW+1)'(NUM_IO);
  localparam logic [AW-1:0]  LAST_ENT  = AW'(NUM_IO - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(CFG_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CFG_W-1:0] cfg_table [NUM_IO];
  logic [BW-1:0]    bit_idx, bit_idx_nxt;
  logic [AW-1:0]    ent_idx, ent_idx_nxt;
  logic             sdo_nxt;
  logic             abort_nxt;
  logic             addr_ok;
  logic             pud_reserved;
  logic             wr_take;
  logic             wr_bad;
  logic [CFG_W-1:0] wr_word;
  logic             last_bit;

  // Write qualification: reserved pull setting is coerced to "none" but still flagged.
  always_comb begin
    addr_ok      = {1'b0, wr_addr} < NUM_IO_W;
    pud_reserved = (wr_data[3:2] == 2'b11);
    wr_word      = wr_data;
    if (pud_reserved) begin
      wr_word[3:2] = 2'b00;
    end
    wr_take = wr_en && (state == IDLE) && addr_ok;
    wr_bad  = wr_en && ((state != IDLE) || !addr_ok || pud_reserved);
  end

  assign last_bit = (bit_idx == '0) && (ent_idx == '0);

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    ent_idx_nxt = ent_idx;
    sdo_nxt     = 1'b0;
    abort_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          bit_idx_nxt = LAST_BIT;
          ent_idx_nxt = LAST_ENT;
          // A write landing on the same edge must already be visible in the first bit.
          if (wr_take && (wr_addr == LAST_ENT)) begin
            sdo_nxt = wr_word[CFG_W-1];
          end else begin
            sdo_nxt = cfg_table[NUM_IO-1][CFG_W-1];
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (last_bit) begin
          state_nxt = LATCH;
        end else begin
          if (bit_idx == '0) begin
            bit_idx_nxt = LAST_BIT;
            ent_idx_nxt = ent_idx - 1'b1;
          end else begin
            bit_idx_nxt = bit_idx - 1'b1;
          end
          sdo_nxt = cfg_table[ent_idx_nxt][bit_idx_nxt];
        end
      end
      LATCH: begin
        if (abort) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // All chain-facing outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      ent_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wr_err    <= 1'b0;
      cfg_sdo   <= 1'b0;
      cfg_shift <= 1'b0;
      cfg_latch <= 1'b0;
      for (int i = 0; i < NUM_IO; i++) begin
        cfg_table[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      ent_idx   <= ent_idx_nxt;
      busy      <= (state_nxt == SHIFT) || (state_nxt == LATCH);
      done      <= (state_nxt == DONE);
      aborted   <= abort_nxt;
      wr_err    <= wr_bad;
      cfg_sdo   <= sdo_nxt;
      cfg_shift <= (state_nxt == SHIFT);
      cfg_latch <= (state_nxt == LATCH);
      if (wr_take) begin
        cfg_table[wr_addr] <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_io_cfg_sequencer.sv
// tb_io_cfg_sequencer: scoreboard bench; a table model predicts the serial stream,
// end events and wr_err pulses, and a negedge monitor compares them.
module tb_io_cfg_sequencer;

  localparam int NUM_IO    = 3;
  localparam int AW        = 2;
  localparam int CFG_W     = 10;
  localparam int TOTAL     = NUM_IO * CFG_W;
  localparam int END_DONE  = 1;
  localparam int END_ABORT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [CFG_W-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, aborted, wr_err, cfg_sdo, cfg_shift, cfg_latch;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [CFG_W-1:0] mdl [NUM_IO];
  bit exp_sdo[$];
  int exp_first[$];
  int exp_end_kind[$];
  int exp_busy_len[$];
  int exp_err[$];

  bit mon_en = 1'b0;
  bit prev_shift = 1'b0;
  bit prev_busy = 1'b0;
  int busy_run = 0;
  int last_run = 0;
  int cur_first = 0;
  int latch_cyc = 0;

  io_cfg_sequencer #(.NUM_IO(NUM_IO), .AW(AW), .CFG_W(CFG_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .wr_err(wr_err), .cfg_sdo(cfg_sdo), .cfg_shift(cfg_shift), .cfg_latch(cfg_latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Table model: writes only land while idle, reserved pull setting becomes "none".
  task automatic model_write(input int addr, input logic [CFG_W-1:0] data, input bit seq_busy);
    bit err;
    err = seq_busy || (addr >= NUM_IO) || (data[3:2] == 2'b11);
    if (!seq_busy && addr < NUM_IO) begin
      mdl[addr] = data;
      if (data[3:2] == 2'b11) mdl[addr][3:2] = 2'b00;
    end
    if (err) exp_err.push_back(addr);
  endtask

  task automatic push_sequence(input int abort_at);
    int n;
    n = 0;
    for (int e = NUM_IO - 1; e >= 0; e--) begin
      for (int b = CFG_W - 1; b >= 0; b--) begin
        if (abort_at == 0 || n < abort_at) exp_sdo.push_back(mdl[e][b]);
        n++;
      end
    end
    exp_first.push_back(cyc + 1);
    exp_end_kind.push_back(abort_at != 0 ? END_ABORT : END_DONE);
    exp_busy_len.push_back(abort_at != 0 ? abort_at : TOTAL + 1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while (exp_end_kind.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (2) @(posedge clk);
    checkOutput("seq_complete", exp_end_kind.size(), 0);
    checkOutput("wr_err_pending", exp_err.size(), 0);
  endtask

  task automatic applyStimulus(input bit do_wr, input int addr, input logic [CFG_W-1:0] data,
                               input bit do_start, input bit idle_abort, input int abort_at,
                               input int mid_wr_at, input int mid_start_at);
    @(posedge clk); #1;
    if (do_wr) begin
      model_write(addr, data, 1'b0);
      wr_en = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
    end
    if (do_start) begin
      push_sequence(abort_at);
      start = 1'b1;
      abort = idle_abort;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    if (do_start) begin
      for (int j = 1; j <= TOTAL + 1; j++) begin
        if (j == mid_wr_at) begin
          wr_addr = AW'($urandom_range(0, 3));
          wr_data = CFG_W'($urandom);
          model_write(int'(wr_addr), wr_data, 1'b1);
          wr_en = 1'b1;
        end
        if (j == mid_start_at) start = 1'b1;
        if (j == abort_at) abort = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        if (j == abort_at) break;
      end
    end
    wait_idle();
  endtask

  task automatic reset_in_latch();
    int budget;
    @(posedge clk); #1;
    push_sequence(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 100;
    while (cfg_latch !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("latch_reached", int'(cfg_latch), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_end_kind.delete();
    exp_busy_len.delete();
    exp_first.delete();
    exp_sdo.delete();
    for (int i = 0; i < NUM_IO; i++) mdl[i] = '0;
    @(negedge clk);
    checkOutput("rst_latch", int'(cfg_latch), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_shift", int'(cfg_shift), 0);
    checkOutput("rst_sdo", int'(cfg_sdo), 0);
    repeat (40) @(negedge clk);
    checkOutput("rst_no_done", exp_end_kind.size(), 0);
  endtask

  // Monitor: every observed output event is matched against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) busy_run++;
      else begin
        if (prev_busy) last_run = busy_run;
        busy_run = 0;
      end
      if (cfg_shift === 1'b1) begin
        if (!prev_shift) begin
          checkOutput("shift_expected", int'(exp_first.size() != 0), 1);
          if (exp_first.size() != 0) begin
            cur_first = cyc;
            checkOutput("first_shift_cycle", cyc, exp_first.pop_front());
          end
        end
        if (exp_sdo.size() != 0) checkOutput("cfg_sdo", int'(cfg_sdo), int'(exp_sdo.pop_front()));
        else checkOutput("unexpected_shift", int'(cfg_shift), 0);
      end else begin
        checkOutput("sdo_idle", int'(cfg_sdo), 0);
      end
      if (cfg_latch === 1'b1) begin
        latch_cyc = cyc;
        checkOutput("latch_shift_low", int'(cfg_shift), 0);
        checkOutput("latch_bits_left", exp_sdo.size(), 0);
        checkOutput("latch_cycle", cyc, cur_first + TOTAL);
        checkOutput("latch_kind", exp_end_kind.size() != 0 ? exp_end_kind[0] : 0, END_DONE);
      end
      if (done === 1'b1) begin
        checkOutput("done_cycle", cyc, latch_cyc + 1);
        checkOutput("done_kind", exp_end_kind.size() != 0 ? exp_end_kind.pop_front() : 0, END_DONE);
        checkOutput("done_busy_len", last_run, exp_busy_len.size() != 0 ? exp_busy_len.pop_front() : -1);
      end
      if (aborted === 1'b1) begin
        checkOutput("abort_shift_low", int'(cfg_shift), 0);
        checkOutput("abort_bits_left", exp_sdo.size(), 0);
        checkOutput("abort_kind", exp_end_kind.size() != 0 ? exp_end_kind.pop_front() : 0, END_ABORT);
        checkOutput("abort_busy_len", last_run, exp_busy_len.size() != 0 ? exp_busy_len.pop_front() : -1);
      end
      if (wr_err === 1'b1) begin
        checkOutput("wr_err_expected", int'(exp_err.size() != 0), 1);
        if (exp_err.size() != 0) void'(exp_err.pop_front());
      end
      prev_shift = (cfg_shift === 1'b1);
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    int kind, addr, abort_at, mid_wr, mid_start;
    logic [CFG_W-1:0] data;
    for (int i = 0; i < NUM_IO; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_aborted", int'(aborted), 0);
    checkOutput("reset_wr_err", int'(wr_err), 0);
    checkOutput("reset_sdo", int'(cfg_sdo), 0);
    checkOutput("reset_shift", int'(cfg_shift), 0);
    checkOutput("reset_latch", int'(cfg_latch), 0);
    mon_en = 1'b1;

    applyStimulus(0, 0, '0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 10'h2A5, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 10'h001, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 10'h3F0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 10'h00C, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0, 5, 9);
    applyStimulus(1, 3, 10'h155, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 12, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0, TOTAL + 1, 0);
    applyStimulus(1, 2, 10'h2B3, 1, 1, 0, 0, 0);
    reset_in_latch();
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      addr = $urandom_range(0, 3);
      data = CFG_W'($urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TOTAL) : 0;
      mid_wr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, abort_at != 0 ? abort_at : TOTAL + 1) : 0;
      mid_start = ($urandom_range(0, 2) == 0) ? $urandom_range(1, abort_at != 0 ? abort_at : TOTAL + 1) : 0;
      if (kind < 2) applyStimulus(1, addr, data, 0, 0, 0, 0, 0);
      else applyStimulus(kind == 3, addr, data, 1, 1'($urandom_range(0, 1)), abort_at, mid_wr, mid_start);
    end

    repeat (5) @(posedge clk);
    checkOutput("final_sdo_queue", exp_sdo.size(), 0);
    checkOutput("final_end_queue", exp_end_kind.size(), 0);
    checkOutput("final_err_queue", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
